// File: rtl/wb_burst_master.sv
// Wishbone B4 burst master: one command becomes a WR or RD burst (incrementing CTI), then a completion report.
// Optional WB_BURST_TIMEOUT_EN adds a no-ack abort counter.
module wb_burst_master #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [DATA_W/8-1:0] req_sel,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [DATA_W-1:0]   wdata,
  output logic                rdata_valid,
  input  logic                rdata_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                done_valid,
  input  logic                done_ready,
  output logic                done_err,
  output logic [LEN_W:0]      done_beats,
  output logic [ADDR_W-1:0]   cfu_ram_adr,
  output logic [DATA_W-1:0]   cfu_ram_dat_mosi,
  output logic [DATA_W/8-1:0] cfu_ram_sel,
  output logic                cfu_ram_cyc,
  output logic                cfu_ram_stb,
  output logic                cfu_ram_we,
  output logic [2:0]          cfu_ram_cti,
  output logic [1:0]          cfu_ram_bte,
  input  logic [DATA_W-1:0]   cfu_ram_dat_miso,
  input  logic                cfu_ram_ack,
  input  logic                cfu_ram_err
);

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t                state;
  logic [ADDR_W-1:0]     addr_r;
  logic [LEN_W-1:0]      len_r;
  logic [DATA_W/8-1:0]   sel_r;
  logic [LEN_W:0]        cnt;
  logic                  active, last_beat, err_hit, ack_hit;

  assign active    = (state == WR) || (state == RD);
  assign last_beat = (cnt[LEN_W-1:0] == len_r);
  assign err_hit   = active && cfu_ram_stb && cfu_ram_err;
  // err wins over a simultaneous ack: that beat is neither counted nor handed to the streams
  assign ack_hit   = active && cfu_ram_stb && cfu_ram_ack && !cfu_ram_err;

  assign req_ready        = (state == IDLE);
  assign done_valid       = (state == RESP);
  assign cfu_ram_cyc      = active;
  assign cfu_ram_we       = (state == WR);
  assign cfu_ram_stb      = (state == WR) ? wdata_valid : (state == RD) ? rdata_ready : 1'b0;
  assign cfu_ram_adr      = addr_r + ADDR_W'(cnt);
  assign cfu_ram_sel      = sel_r;
  assign cfu_ram_dat_mosi = wdata;
  assign cfu_ram_cti      = (!active || len_r == '0) ? 3'b000 : last_beat ? 3'b111 : 3'b010;
  assign cfu_ram_bte      = 2'b00;
  assign wdata_ready      = (state == WR) && ack_hit;
  assign rdata_valid      = (state == RD) && ack_hit;
  assign rdata            = cfu_ram_dat_miso;

`ifdef WB_BURST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo;
  logic             stall;
  assign stall = active && cfu_ram_stb && !cfu_ram_ack && !cfu_ram_err;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      done_err   <= 1'b0;
      done_beats <= '0;
`ifdef WB_BURST_TIMEOUT_EN
      tmo        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          addr_r <= req_addr;
          len_r  <= req_len;
          sel_r  <= req_sel;
          cnt    <= '0;
`ifdef WB_BURST_TIMEOUT_EN
          tmo    <= '0;
`endif
          state  <= req_we ? WR : RD;
        end
        WR, RD: begin
          if (err_hit) begin
            state      <= RESP;
            done_err   <= 1'b1;
            done_beats <= cnt;
          end else if (ack_hit) begin
            cnt <= cnt + 1'b1;
`ifdef WB_BURST_TIMEOUT_EN
            tmo <= '0;
`endif
            if (last_beat) begin
              state      <= RESP;
              done_err   <= 1'b0;
              done_beats <= cnt + 1'b1;
            end
          end
`ifdef WB_BURST_TIMEOUT_EN
          else if (stall) begin
            tmo <= tmo + 1'b1;
            if (tmo == TMO_W'(TIMEOUT - 1)) begin
              state      <= RESP;
              done_err   <= 1'b1;
              done_beats <= cnt;
            end
          end
`endif
        end
        RESP: if (done_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed per-cycle vector table for wb_burst_master, plus a hand-written stall/timeout sequence.
module tb_wb_burst_master;
  localparam int AW = 30, DW = 32, LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [3:0]    req_sel;
  logic          wdata_valid, wdata_ready, rdata_valid, rdata_ready;
  logic [DW-1:0] wdata, rdata;
  logic          done_valid, done_ready, done_err;
  logic [LW:0]   done_beats;
  logic [AW-1:0] adr;
  logic [DW-1:0] mosi, miso;
  logic [3:0]    sel;
  logic          cyc, stb, we, ack, err;
  logic [2:0]    cti;
  logic [1:0]    bte;

  wb_burst_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_sel(req_sel),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .done_valid(done_valid), .done_ready(done_ready), .done_err(done_err), .done_beats(done_beats),
    .cfu_ram_adr(adr), .cfu_ram_dat_mosi(mosi), .cfu_ram_sel(sel), .cfu_ram_cyc(cyc),
    .cfu_ram_stb(stb), .cfu_ram_we(we), .cfu_ram_cti(cti), .cfu_ram_bte(bte),
    .cfu_ram_dat_miso(miso), .cfu_ram_ack(ack), .cfu_ram_err(err)
  );

  typedef struct {
    logic rst, rv, rwe; logic [AW-1:0] a; logic [LW-1:0] l; logic [3:0] s;
    logic wv, rr, ack, err; logic [DW-1:0] d; logic dr;
    logic rq, cy, st, we; logic [2:0] cti; logic [AW-1:0] ea; logic [3:0] es;
    logic dv, de; logic [LW:0] db; logic rvl, wrd; logic [DW-1:0] ed;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;
  int nvec = 0, nmis = 0;

  task automatic vin(input logic rst, rv, rwe, input logic [AW-1:0] a, input logic [LW-1:0] l,
                     input logic [3:0] s, input logic wv, rr, ak, er, input logic [DW-1:0] d, input logic dr);
    cur.rst = rst; cur.rv = rv; cur.rwe = rwe; cur.a = a; cur.l = l; cur.s = s;
    cur.wv = wv; cur.rr = rr; cur.ack = ak; cur.err = er; cur.d = d; cur.dr = dr;
  endtask

  task automatic vexp(input logic rq, cy, st, w, input logic [2:0] c, input logic [AW-1:0] ea,
                      input logic [3:0] es, input logic dv, de, input logic [LW:0] db,
                      input logic rvl, wrd, input logic [DW-1:0] ed);
    cur.rq = rq; cur.cy = cy; cur.st = st; cur.we = w; cur.cti = c; cur.ea = ea; cur.es = es;
    cur.dv = dv; cur.de = de; cur.db = db; cur.rvl = rvl; cur.wrd = wrd; cur.ed = ed;
    tbl.push_back(cur);
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; req_valid = v.rv; req_we = v.rwe; req_addr = v.a; req_len = v.l; req_sel = v.s;
    wdata_valid = v.wv; rdata_ready = v.rr; ack = v.ack; err = v.err;
    wdata = v.d; miso = v.d; done_ready = v.dr;
  endtask

  task automatic check(input int idx, input vec_t v);
    logic ok;
    ok = (req_ready == v.rq) && (cyc == v.cy) && (stb == v.st) && (we == v.we) && (cti == v.cti) &&
         (bte == 2'b00) && (done_valid == v.dv) && (rdata_valid == v.rvl) && (wdata_ready == v.wrd);
    if (v.cy) ok = ok && (adr == v.ea) && (sel == v.es);
    if (v.dv) ok = ok && (done_err == v.de) && (done_beats == v.db);
    if (v.st && v.we) ok = ok && (mosi == v.ed);
    if (v.rvl) ok = ok && (rdata == v.ed);
    nvec++;
    if (!ok) begin
      nmis++;
      $display("FAIL vec%0d: got rq%b cyc%b stb%b we%b cti%b bte%b adr%h sel%h dv%b de%b db%0d rv%b wr%b rd%h wd%h | need rq%b cyc%b stb%b we%b cti%b adr%h sel%h dv%b de%b db%0d rv%b wr%b data%h",
               idx, req_ready, cyc, stb, we, cti, bte, adr, sel, done_valid, done_err, done_beats,
               rdata_valid, wdata_ready, rdata, mosi,
               v.rq, v.cy, v.st, v.we, v.cti, v.ea, v.es, v.dv, v.de, v.db, v.rvl, v.wrd, v.ed);
    end
  endtask

  task automatic cmp(input string name, input int got, input int need);
    nvec++;
    if (got != need) begin
      nmis++;
      $display("FAIL %s: got %0d need %0d", name, got, need);
    end
  endtask

  int n;

  initial begin
    // reset state and idle ignoring streams
    vin(0,0,0,0,0,0,0,0,0,0,0,0);              vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,1,1,1,0,0,0);              vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    // single write, ack one cycle late; request during RESP must wait
    vin(0,1,1,'h100,0,'hF,0,0,0,0,0,0);        vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,1,0,0,0,'hDEADBEEF,0);     vexp(0,1,1,1,0,'h100,'hF,0,0,0,0,0,'hDEADBEEF);
    vin(0,0,0,0,0,0,1,0,1,0,'hDEADBEEF,0);     vexp(0,1,1,1,0,'h100,'hF,0,0,0,0,1,'hDEADBEEF);
    vin(0,1,0,'h999,0,0,0,0,0,0,0,0);          vexp(0,0,0,0,0,0,0,1,0,1,0,0,0);
    vin(0,0,0,0,0,0,0,0,0,0,0,1);              vexp(0,0,0,0,0,0,0,1,0,1,0,0,0);
    vin(0,0,0,0,0,0,0,0,0,0,0,0);              vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    // 4-beat read
    vin(0,1,0,'h200,3,'hF,0,0,0,0,0,0);        vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,0,1,1,0,'h11,0);           vexp(0,1,1,0,2,'h200,'hF,0,0,0,1,0,'h11);
    vin(0,0,0,0,0,0,0,1,1,0,'h22,0);           vexp(0,1,1,0,2,'h201,'hF,0,0,0,1,0,'h22);
    vin(0,0,0,0,0,0,0,1,1,0,'h33,0);           vexp(0,1,1,0,2,'h202,'hF,0,0,0,1,0,'h33);
    vin(0,0,0,0,0,0,0,1,1,0,'h44,0);           vexp(0,1,1,0,7,'h203,'hF,0,0,0,1,0,'h44);
    vin(0,0,0,0,0,0,0,0,0,0,0,1);              vexp(0,0,0,0,0,0,0,1,0,4,0,0,0);
    // 4-beat write with a 2-cycle wdata gap; rdata_ready ignored in WR
    vin(0,1,1,'h300,3,'h3,0,0,0,0,0,0);        vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,1,0,1,0,'hA0,0);           vexp(0,1,1,1,2,'h300,'h3,0,0,0,0,1,'hA0);
    vin(0,0,0,0,0,0,0,1,0,0,0,0);              vexp(0,1,0,1,2,'h301,'h3,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,0,1,0,0,0,0);              vexp(0,1,0,1,2,'h301,'h3,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,1,0,1,0,'hA1,0);           vexp(0,1,1,1,2,'h301,'h3,0,0,0,0,1,'hA1);
    vin(0,0,0,0,0,0,1,0,1,0,'hA2,0);           vexp(0,1,1,1,2,'h302,'h3,0,0,0,0,1,'hA2);
    vin(0,0,0,0,0,0,1,0,1,0,'hA3,0);           vexp(0,1,1,1,7,'h303,'h3,0,0,0,0,1,'hA3);
    vin(0,0,0,0,0,0,0,0,0,0,0,1);              vexp(0,0,0,0,0,0,0,1,0,4,0,0,0);
    // 8-beat read, err (with simultaneous ack) on the third beat
    vin(0,1,0,'h400,7,'hF,0,0,0,0,0,0);        vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,0,1,1,0,'h1,0);            vexp(0,1,1,0,2,'h400,'hF,0,0,0,1,0,'h1);
    vin(0,0,0,0,0,0,0,1,1,0,'h2,0);            vexp(0,1,1,0,2,'h401,'hF,0,0,0,1,0,'h2);
    vin(0,0,0,0,0,0,0,1,1,1,'h3,0);            vexp(0,1,1,0,2,'h402,'hF,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,0,1,0,0,0,0);              vexp(0,0,0,0,0,0,0,1,1,2,0,0,0);
    vin(0,0,0,0,0,0,0,0,0,0,0,1);              vexp(0,0,0,0,0,0,0,1,1,2,0,0,0);
    // 16-beat write wrapping past 2^30, reset on beat 2
    vin(0,1,1,'h3FFFFFFE,15,'hF,0,0,0,0,0,0);  vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,1,0,1,0,'hB0,0);           vexp(0,1,1,1,2,'h3FFFFFFE,'hF,0,0,0,0,1,'hB0);
    vin(0,0,0,0,0,0,1,0,1,0,'hB1,0);           vexp(0,1,1,1,2,'h3FFFFFFF,'hF,0,0,0,0,1,'hB1);
    vin(1,0,0,0,0,0,1,0,1,0,'hB2,0);           vexp(0,1,1,1,2,'h0,'hF,0,0,0,0,1,'hB2);
    vin(0,0,0,0,0,0,1,1,0,0,0,0);              vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);
    vin(0,0,0,0,0,0,0,0,0,0,0,0);              vexp(1,0,0,0,0,0,0,0,0,0,0,0,0);

    vin(1,0,0,0,0,0,0,0,0,0,0,0);
    apply(cur);
    repeat (2) @(negedge clk);

    foreach (tbl[k]) begin
      @(negedge clk);
      apply(tbl[k]);
      #1 check(k, tbl[k]);
    end

    // single-beat read against a slave that stalls
    @(negedge clk);
    vin(0,1,0,'h500,0,'hF,0,0,0,0,0,0); apply(cur);
    @(negedge clk);
    vin(0,0,0,0,0,0,0,1,0,0,'h55,0); apply(cur);
    n = 0;
    while (!done_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
`ifdef WB_BURST_TIMEOUT_EN
    cmp("timeout_cycles", n, 8);
    cmp("timeout_err", int'(done_err), 1);
    cmp("timeout_beats", int'(done_beats), 0);
`else
    cmp("no_timeout_wait", n, 30);
    cmp("no_timeout_cyc", int'(cyc), 1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1;
    cmp("late_ack_done", int'(done_valid), 1);
    cmp("late_ack_err", int'(done_err), 0);
    cmp("late_ack_beats", int'(done_beats), 1);
`endif
    done_ready = 1'b1;
    rdata_ready = 1'b0;
    @(negedge clk);
    done_ready = 1'b0;
    #1 cmp("back_to_idle", int'(req_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, Wishbone word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; SEL width is DATA_W/8.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum beats per transfer (power of two, 1..256).
REQ-004 SHALL have parameter LEN_W = clog2(MAX_BURST), derived, request length field width (minimum 1).
REQ-005 SHALL have parameter TIMEOUT, default 255, no-ack cycle limit when REQ-030 is enabled.
REQ-006 SHALL have port clk, in, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port reset, in, 1: one clock; reset is synchronous and active-high.
REQ-008 SHALL have ports req_valid/req_ready, in/out, 1 each, command handshake.
REQ-009 SHALL have ports req_we (in, 1), req_addr (in, ADDR_W), req_len (in, LEN_W, beats minus one) and req_sel (in, DATA_W/8).
REQ-010 SHALL have ports wdata_valid/wdata_ready, in/out, 1 each, and wdata, in, DATA_W, write stream.
REQ-011 SHALL have ports rdata_valid (out, 1), rdata_ready (in, 1) and rdata (out, DATA_W), read stream.
REQ-012 SHALL have ports done_valid (out, 1), done_ready (in, 1), done_err (out, 1) and done_beats (out, LEN_W+1), completion report.
REQ-013 SHALL have ports cfu_ram_adr (out, ADDR_W), cfu_ram_dat_mosi (out, DATA_W), cfu_ram_sel (out, DATA_W/8), cfu_ram_cyc, cfu_ram_stb, cfu_ram_we (out, 1 each), cfu_ram_cti (out, 3), cfu_ram_bte (out, 2), cfu_ram_dat_miso (in, DATA_W), cfu_ram_ack and cfu_ram_err (in, 1 each).

Function
REQ-014 SHALL implement FSM states IDLE, WR, RD and RESP.
REQ-015 SHALL assert req_ready only in IDLE; on req_valid&req_ready, SHALL latch we/addr/len/sel, clear the beat counter and enter WR (req_we=1) or RD (req_we=0).
REQ-016 SHALL hold cfu_ram_cyc=1 throughout WR/RD and 0 in IDLE/RESP.
REQ-017 In WR, SHALL drive cfu_ram_stb=wdata_valid, cfu_ram_we=1, cfu_ram_dat_mosi=wdata, and wdata_ready=cfu_ram_ack.
REQ-018 In RD, SHALL drive cfu_ram_stb=rdata_ready, cfu_ram_we=0, rdata=cfu_ram_dat_miso and rdata_valid=cfu_ram_ack; no internal read buffering.
REQ-019 SHALL drive cfu_ram_adr = latched addr + beat counter, modulo 2^ADDR_W (wraps silently), and cfu_ram_sel = latched sel on every beat.
REQ-020 SHALL drive cfu_ram_cti: 000 when len=0; otherwise 010 for beats before the last and 111 on the last beat; cfu_ram_bte SHALL be constant 00.
REQ-021 SHALL increment the beat counter on each cycle with cyc&stb&ack, and enter RESP with done_err=0 on the ack of beat len.
REQ-022 SHALL, on cfu_ram_err while cyc&stb, end the cycle, enter RESP with done_err=1, and exclude the errored beat from the count; err takes priority over a simultaneous ack.
REQ-023 SHALL report done_beats = number of acked beats in RESP, where done_valid=1; RESP SHALL exit to IDLE on done_ready, and no new request SHALL be accepted before that.
REQ-024 SHALL never assert cfu_ram_stb outside WR/RD; the one-cycle latency from request acceptance to the first stb is fixed.
REQ-025 SHALL ignore wdata_valid outside WR and rdata_ready outside RD; wdata_ready and rdata_valid SHALL be 0 there.

Reset
REQ-026 SHALL, on reset, enter IDLE, clear the beat counter, done_err, done_beats and the timeout counter, regardless of state.
REQ-027 SHALL provide post-reset outputs: req_ready=1; done_valid, rdata_valid, wdata_ready, cyc, stb, we = 0; cti=000; bte=00.
REQ-028 SHALL, on reset mid-burst, drop cyc/stb on the same edge, abandoning the burst without a completion report.
REQ-029 SHALL give reset priority over all other inputs.

Configuration
REQ-030 SHALL, with macro WB_BURST_TIMEOUT_EN defined, count consecutive WR/RD cycles with stb=1 and no ack/err, reset the count on ack, and on reaching TIMEOUT abort to RESP with done_err=1.
REQ-031 SHALL, without WB_BURST_TIMEOUT_EN, omit the counter entirely and wait indefinitely for ack/err.

Verification
REQ-032 SHALL cover single write: addr=0x100, len=0, sel=0xF, wdata=0xDEADBEEF, ack next cycle -> one stb, cti=000, we=1; done_beats=1, done_err=0.
REQ-033 SHALL cover 4-beat read: addr=0x200, len=3, slave returns 0x11..0x44 -> adr 0x200..0x203, cti 010,010,010,111; rdata sequence 0x11,0x22,0x33,0x44; done_beats=4.
REQ-034 SHALL cover stalls: 4-beat write with wdata_valid low for 2 cycles after beat 1 -> stb low during the gap, cyc held high, addresses contiguous, done_beats=4.
REQ-035 SHALL cover error: 8-beat read with err on beat 3 -> cyc drops, done_err=1, done_beats=2.
REQ-036 SHALL cover reset mid-burst: reset during beat 2 of a 16-beat write -> cyc=0 after the edge, no done_valid, req_ready=1.
REQ-037 SHALL cover timeout (WB_BURST_TIMEOUT_EN, TIMEOUT=8): slave never acks -> done_err=1 after 8 stalled cycles, done_beats=0.
